// File: rtl/mem_pipe_responder.sv
// -----------------------------------------------------------------------------
// mem_pipe_responder
//
// Main-memory responder sitting at the far end of the cache fill interface.
// It accepts one request per cycle:
//   - a write whenever wr=1, or
//   - a read when enable=1 and wr=0.
// Read data returns through an in-order, fixed-latency pipeline.
//
// Handshake: there is no ready/back-pressure.
//   - Requests are taken on every rising edge where init_busy=0 and rst=0.
//   - data_valid is a one-cycle pulse per completed read.
//   - data_out is meaningful only while data_valid=1; between pulses it holds
//     the last returned word.
//
// Parameters:
//   LATENCY  accept edge to data_valid, in cycles (1..8)
//   MEM_AW   word-address width of the array (2^MEM_AW x 16-bit words,
//            MEM_AW <= 14)
//   CNT_W    width of the pending counter (2^CNT_W > LATENCY)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   enable      read request strobe (ignored when wr=1)
//   wr          write strobe
//   addr        byte address; word index = addr[MEM_AW:1]
//   data_in     write data
//   data_out    read data
//   data_valid  read completion pulse
//   pending     reads accepted but not yet returned
//   init_busy   array clear sweep in progress
//
// Optional feature, macro MEMRESP_INIT_CLEAR_EN:
//   - After reset, the whole array is cleared to zero, one word per cycle.
//   - Requests are ignored while the clear is running.
//   - Without the macro, init_busy is tied low and the array is left
//     uninitialised.
// -----------------------------------------------------------------------------
module mem_pipe_responder #(
  parameter int LATENCY = 4,
  parameter int MEM_AW  = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr,
  input  logic [15:0]      addr,
  input  logic [15:0]      data_in,
  output logic [15:0]      data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] pending,
  output logic             init_busy
);

  localparam int DEPTH = 1 << MEM_AW;

  // ---------------------------------------------------------------------------
  // Storage and request decode
  // ---------------------------------------------------------------------------
  logic [15:0]       r_mem [DEPTH];

  logic [MEM_AW-1:0] w_idx;
  logic              w_busy;
  logic              w_write;
  logic              w_accept;
  logic              w_mem_we;
  logic [MEM_AW-1:0] w_mem_waddr;
  logic [15:0]       w_mem_wdata;

  // addr[0] and the bits above the array index are deliberately dropped
  // (upper addresses alias onto the array).
  logic              w_unused_addr;
  assign w_unused_addr = ^{addr[15:MEM_AW+1], addr[0]};

  assign w_idx    = addr[MEM_AW:1];

  // Write wins over read: a cycle with wr=1 never issues a read.
  assign w_write  = wr & ~w_busy & ~rst;
  assign w_accept = enable & ~wr & ~w_busy & ~rst;

`ifdef MEMRESP_INIT_CLEAR_EN
  // ---------------------------------------------------------------------------
  // Post-reset clear sweep.
  // r_init_busy is registered alongside the state, so init_busy is a clean
  // flop output that drops on the edge that writes the last word.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [MEM_AW-1:0] r_sweep;
  logic              r_init_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset during the sweep restarts it from word 0.
      r_state     <= S_CLEAR;
      r_sweep     <= '0;
      r_init_busy <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_sweep <= r_sweep + MEM_AW'(1);
          if (r_sweep == {MEM_AW{1'b1}}) begin
            r_state     <= S_READY;
            r_init_busy <= 1'b0;
          end
        end
        S_READY: begin
          r_state     <= S_READY;
          r_init_busy <= 1'b0;
        end
      endcase
    end
  end

  assign w_busy      = r_init_busy;
  assign init_busy   = r_init_busy;

  // The sweep owns the write port while it runs; requests are blocked then
  // anyway.
  assign w_mem_we    = (r_init_busy & ~rst) | w_write;
  assign w_mem_waddr = r_init_busy ? r_sweep : w_idx;
  assign w_mem_wdata = r_init_busy ? 16'h0000 : data_in;
`else
  assign w_busy      = 1'b0;
  assign init_busy   = 1'b0;
  assign w_mem_we    = w_write;
  assign w_mem_waddr = w_idx;
  assign w_mem_wdata = data_in;
`endif

  // Array contents are intentionally not touched by rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  // Each read samples the array on its accept edge. The word then travels
  // with a valid bit, so a later write to the same word cannot disturb it.
  //
  // Stage LATENCY-1 is the output register, which puts data_valid high in
  // the cycle after edge N+LATENCY-1.
  //
  // Data registers only load when the stage feeding them is valid. This is
  // what makes data_out hold its last value between pulses.
  // ---------------------------------------------------------------------------
  logic        r_pv [LATENCY];
  logic [15:0] r_pd [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Flushing the valid bits discards every in-flight read.
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
      end
      r_pd[LATENCY-1] <= 16'h0000;
    end else begin
      r_pv[0] <= w_accept;
      if (w_accept) begin
        r_pd[0] <= r_mem[w_idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
        end
      end
    end
  end

  assign data_valid = r_pv[LATENCY-1];
  assign data_out   = r_pd[LATENCY-1];

  // ---------------------------------------------------------------------------
  // In-flight read counter.
  // A read retires on the edge that ends its data_valid cycle. The count is
  // therefore bounded by LATENCY and cannot wrap, given the parameter rule.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      case ({w_accept, data_valid})
        2'b10:   r_pending <= r_pending + CNT_W'(1);
        2'b01:   r_pending <= r_pending - CNT_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_mem_pipe_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_pipe_responder
//
// Directed bench for mem_pipe_responder with the default parameters
// (LATENCY=4, MEM_AW=10, CNT_W=4).
//
// Stimulus pushes the hand-computed expected read word into exp_q. A
// separate monitor pops and compares on every data_valid pulse; a pulse
// with an empty queue is an error.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// at the same point or on the falling edge.
//
// When built with MEMRESP_INIT_CLEAR_EN defined, the post-reset clear is
// exercised as well.
// -----------------------------------------------------------------------------
module tb_mem_pipe_responder;

  localparam int LATENCY = 4;
  localparam int MEM_AW  = 10;
  localparam int CNT_W   = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             wr = 1'b0;
  logic [15:0]      addr = 16'h0000;
  logic [15:0]      data_in = 16'h0000;
  logic [15:0]      data_out;
  logic             data_valid;
  logic [CNT_W-1:0] pending;
  logic             init_busy;

  always #5 clk = ~clk;

  mem_pipe_responder #(
    .LATENCY (LATENCY),
    .MEM_AW  (MEM_AW),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .pending    (pending),
    .init_busy  (init_busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];

  // Pulse statistics, gathered at each post-edge sample point.
  int          cyc = 0;
  int          dv_cnt = 0;
  int          dv_first = -1;
  int          dv_last = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid === 1'b1) begin
      dv_cnt++;
      if (dv_first < 0) dv_first = cyc;
      dv_last = cyc;
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wr      = 1'b1;
    enable  = 1'b0;
    addr    = a;
    data_in = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] e, input bit push = 1'b1);
    wr     = 1'b0;
    enable = 1'b1;
    addr   = a;
    if (push) exp_q.push_back(e);
    tick();
    enable = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops and compares on every response pulse.
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_dv: data_out=%h with no read outstanding", data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin
            failures++;
            $display("FAIL read_data: got %h expected %h", data_out, e);
          end
        end
      end
    end
  end

  // Watchdog: the bench must always terminate.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          n;
    int          peak;
    logic [15:0] rec_exp;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_data_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_pending", {28'b0, pending}, 32'd0);
    chk("rst_data_out", {16'b0, data_out}, 32'h0000);

`ifdef MEMRESP_INIT_CLEAR_EN
    // Clear sweep: the read issued inside the window must be ignored.
    chk("init_busy_after_rst", {31'b0, init_busy}, 32'd1);
    enable = 1'b1;
    addr   = 16'h0000;
    tick();
    enable = 1'b0;
    n = 1;
    while (init_busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("init_busy_cycles", n, 32'd1024);
    chk("pending_after_clear", {28'b0, pending}, 32'd0);
    do_read(16'h0010, 16'h0000);
    do_read(16'h07FE, 16'h0000);
    drain(6);
`else
    chk("init_busy_tied_low", {31'b0, init_busy}, 32'd0);
`endif

    // Single write then read: exact latency and pending profile.
    do_write(16'h0010, 16'hBEEF);
    do_read(16'h0010, 16'hBEEF);                          // accept edge N
    chk("t1_pending_n0", {28'b0, pending}, 32'd1);
    tick();                                               // after N+1
    chk("t1_pending_n1", {28'b0, pending}, 32'd1);
    chk("t1_dv_n1", {31'b0, data_valid}, 32'd0);
    tick();                                               // after N+2
    chk("t1_pending_n2", {28'b0, pending}, 32'd1);
    chk("t1_dv_n2", {31'b0, data_valid}, 32'd0);
    tick();                                               // after N+3
    chk("t1_pending_n3", {28'b0, pending}, 32'd1);
    chk("t1_dv_n3", {31'b0, data_valid}, 32'd1);
    tick();                                               // after N+4
    chk("t1_pending_n4", {28'b0, pending}, 32'd0);
    chk("t1_dv_n4", {31'b0, data_valid}, 32'd0);

    // Line fill: 8 back-to-back reads stream back in 8 consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      do_write(16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
    end
    dv_cnt   = 0;
    dv_first = -1;
    dv_last  = -1;
    peak     = 0;
    for (int i = 0; i < 8; i++) begin
      do_read(16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
      if (int'(pending) > peak) peak = int'(pending);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (int'(pending) > peak) peak = int'(pending);
    end
    chk("fill_pulse_count", dv_cnt, 32'd8);
    chk("fill_pulse_span", dv_last - dv_first + 1, 32'd8);
    chk("fill_pending_peak", peak, 32'd4);
    chk("fill_pending_end", {28'b0, pending}, 32'd0);

    // Read-at-issue hazard: a later write must not affect an in-flight read.
    do_write(16'h0020, 16'h1111);
    do_read(16'h0020, 16'h1111);
    do_write(16'h0020, 16'h2222);
    do_read(16'h0020, 16'h2222);
    drain(6);

    // Address aliasing, plus data_out holding between pulses.
    do_write(16'h0811, 16'h5A5A);
    do_read(16'h0810, 16'h5A5A);
    do_read(16'h0010, 16'h5A5A);
    drain(6);
    chk("hold_dv_low", {31'b0, data_valid}, 32'd0);
    chk("hold_data_out", {16'b0, data_out}, 32'h5A5A);

    // Reset with three reads in flight: all of them are discarded.
    do_read(16'h0100, 16'h0000, 1'b0);
    do_read(16'h0102, 16'h0000, 1'b0);
    do_read(16'h0104, 16'h0000, 1'b0);
    chk("midrst_pending_before", {28'b0, pending}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_dv", {31'b0, data_valid}, 32'd0);
    chk("midrst_pending", {28'b0, pending}, 32'd0);
    chk("midrst_data_out", {16'b0, data_out}, 32'h0000);
    dv_cnt = 0;
    drain(8);
    chk("midrst_no_stale_dv", dv_cnt, 32'd0);

`ifdef MEMRESP_INIT_CLEAR_EN
    n = 0;
    while (init_busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("reclear_done", {31'b0, init_busy}, 32'd0);
    rec_exp = 16'h0000;
`else
    rec_exp = 16'hA000;
`endif

    // Recovery after reset
    do_read(16'h0100, rec_exp);
    drain(6);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
